// File: rtl/clk_rate_divider_bank.sv
// Bank of NUM_CH programmable 50%-duty clock dividers with tick strobe and 8-bit tick counter.
// All outputs registered (1-cycle from state); no backpressure, half-period changes land on phase boundaries.
module clk_rate_divider_bank #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter logic [NUM_CH*CNT_W-1:0] DEF_HALF = {32'd12_500_000, 32'd50_000_000}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     ch_en,
  input  logic                  restart,
  input  logic                  cfg_wr,
  input  logic [2:0]            cfg_ch,
  input  logic [CNT_W-1:0]      cfg_half,
  output logic [NUM_CH-1:0]     clk_out,
  output logic [NUM_CH-1:0]     tick,
  output logic [NUM_CH*8-1:0]   tick_cnt
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [2:0]       CH_IDX   = 3'(i);
    localparam logic [CNT_W-1:0] RST_HALF = DEF_HALF[i*CNT_W +: CNT_W];

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active_h;
    logic [CNT_W-1:0] pending_h;
    logic [CNT_W-1:0] next_pending;
    logic [7:0]       tcnt;
    logic             clk_q;
    logic             tick_q;
    logic             wr_hit;
    logic             terminal;

    // Writes addressed to channels that do not exist match no instance and vanish.
    assign wr_hit       = cfg_wr && (cfg_ch == CH_IDX);
    assign next_pending = wr_hit ? cfg_half : pending_h;

    // >= rather than == so a period shortened while paused cannot overrun the counter.
    assign terminal = (active_h != '0) && (cnt >= active_h - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt       <= '0;
        clk_q     <= 1'b0;
        tick_q    <= 1'b0;
        tcnt      <= '0;
        active_h  <= RST_HALF;
        pending_h <= RST_HALF;
      end else begin
        pending_h <= next_pending;
        tick_q    <= 1'b0;
        if (restart) begin
          cnt      <= '0;
          clk_q    <= 1'b0;
          active_h <= next_pending;
        end else if (active_h == '0) begin
          cnt      <= '0;
          clk_q    <= 1'b0;
          active_h <= next_pending;
        end else if (!ch_en[i]) begin
          active_h <= next_pending;
        end else if (terminal) begin
          cnt      <= '0;
          active_h <= next_pending;
          // Going idle at a phase boundary parks the output low instead of starting a new half-phase.
          if (next_pending == '0) begin
            clk_q <= 1'b0;
          end else begin
            clk_q <= ~clk_q;
            if (!clk_q) begin
              tick_q <= 1'b1;
              tcnt   <= tcnt + 8'd1;
            end
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign clk_out[i]          = clk_q;
    assign tick[i]             = tick_q;
    assign tick_cnt[i*8 +: 8]  = tcnt;
  end

endmodule
